// File: rtl/tl_ul_mem_responder.sv
// TileLink-UL responder: terminates channel A on an internal word-addressed SRAM
// and returns AccessAck / AccessAckData on channel D with single-cycle latency.
module tl_ul_mem_responder #(
  parameter int TL_ADDR_BITS   = 32,
  parameter int TL_DATA_BYTES  = 4,
  parameter int TL_SIZE_BITS   = 3,
  parameter int TL_SOURCE_BITS = 8,
  parameter int MEM_DEPTH      = 256,
  parameter logic [TL_ADDR_BITS-1:0] BASE_ADDR = {TL_ADDR_BITS{1'b0}}
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          a_valid,
  output logic                          a_ready,
  input  logic [2:0]                    a_opcode,
  input  logic [2:0]                    a_param,
  input  logic [TL_SIZE_BITS-1:0]       a_size,
  input  logic [TL_SOURCE_BITS-1:0]     a_source,
  input  logic [TL_ADDR_BITS-1:0]       a_address,
  input  logic [TL_DATA_BYTES-1:0]      a_mask,
  input  logic [TL_DATA_BYTES*8-1:0]    a_data,
  output logic                          d_valid,
  input  logic                          d_ready,
  output logic [2:0]                    d_opcode,
  output logic [TL_SIZE_BITS-1:0]       d_size,
  output logic [TL_SOURCE_BITS-1:0]     d_source,
  output logic                          d_denied,
  output logic                          d_corrupt,
  output logic [TL_DATA_BYTES*8-1:0]    d_data,
  output logic                          mem_write_valid,
  output logic [TL_ADDR_BITS-1:0]       mem_write_addr,
  output logic [TL_DATA_BYTES*8-1:0]    mem_write_data,
  output logic [TL_DATA_BYTES-1:0]      mem_write_mask
);

  localparam int DW        = TL_DATA_BYTES * 8;
  localparam int LANE_BITS = $clog2(TL_DATA_BYTES);
  localparam int IDX_BITS  = $clog2(MEM_DEPTH);
  localparam int SPAN_BITS = LANE_BITS + IDX_BITS;
  localparam logic [TL_SIZE_BITS-1:0] MAX_SIZE = TL_SIZE_BITS'(LANE_BITS);
  localparam logic [2:0] OP_PUT_FULL = 3'd0;
  localparam logic [2:0] OP_PUT_PART = 3'd1;
  localparam logic [2:0] OP_GET      = 3'd4;

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_e;

  state_e                      state_q, state_d;
  logic [2:0]                  d_opcode_q, d_opcode_d;
  logic [TL_SIZE_BITS-1:0]     d_size_q, d_size_d;
  logic [TL_SOURCE_BITS-1:0]   d_source_q, d_source_d;
  logic                        d_denied_q, d_denied_d;
  logic                        d_corrupt_q, d_corrupt_d;
  logic [DW-1:0]               d_data_q;
  logic [DW-1:0]               mem_q [MEM_DEPTH];

  logic [TL_ADDR_BITS:0]       offset;
  logic [IDX_BITS-1:0]         word_idx;
  logic [LANE_BITS-1:0]        lane_off;
  logic [TL_DATA_BYTES-1:0]    size_mask;
  logic                        in_range, aligned, is_put, is_get, denied;
  logic                        a_fire, wr_en, rd_en;

  // The borrow bit of the widened subtraction flags addresses below BASE_ADDR.
  assign offset   = {1'b0, a_address} - {1'b0, BASE_ADDR};
  assign in_range = (offset >> SPAN_BITS) == {(TL_ADDR_BITS+1){1'b0}};
  assign word_idx = offset[SPAN_BITS-1:LANE_BITS];
  assign lane_off = offset[LANE_BITS-1:0];

  always_comb begin
    is_put = 1'b0;
    is_get = 1'b0;
    case (a_opcode)
      OP_PUT_FULL, OP_PUT_PART: is_put = 1'b1;
      OP_GET:                   is_get = 1'b1;
      default: begin
        is_put = 1'b0;
        is_get = 1'b0;
      end
    endcase
  end

  // Lanes sharing the 2^a_size block containing lane_off; equals the contiguous mask once aligned.
  always_comb begin
    size_mask = {TL_DATA_BYTES{1'b0}};
    for (int i = 0; i < TL_DATA_BYTES; i++) begin
      if ((i >> a_size) == (int'(lane_off) >> a_size)) size_mask[i] = 1'b1;
      else size_mask[i] = 1'b0;
    end
    aligned = ((int'(lane_off) >> a_size) << a_size) == int'(lane_off);
  end

  assign denied = !in_range || !(is_put || is_get) || (a_param != 3'd0) ||
                  (a_size > MAX_SIZE) || !aligned ||
                  ((a_opcode == OP_PUT_FULL) && (a_mask != size_mask)) ||
                  (is_put && (a_mask == {TL_DATA_BYTES{1'b0}}));

  assign a_ready = rst_n && ((state_q == ST_EMPTY) || d_ready);
  assign a_fire  = a_valid && a_ready;
  assign wr_en   = a_fire && is_put && !denied;
  assign rd_en   = a_fire && is_get && !denied;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (a_fire) state_d = ST_FULL; else state_d = ST_EMPTY;
      ST_FULL:  if (d_ready && !a_fire) state_d = ST_EMPTY; else state_d = ST_FULL;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_comb begin
    d_opcode_d  = d_opcode_q;
    d_size_d    = d_size_q;
    d_source_d  = d_source_q;
    d_denied_d  = d_denied_q;
    d_corrupt_d = d_corrupt_q;
    if (a_fire) begin
      d_opcode_d  = is_get ? 3'd1 : 3'd0;
      d_size_d    = a_size;
      d_source_d  = a_source;
      d_denied_d  = denied;
      d_corrupt_d = is_get && denied;
    end else begin
      d_opcode_d  = d_opcode_q;
      d_denied_d  = d_denied_q;
      d_corrupt_d = d_corrupt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      d_opcode_q  <= 3'd0;
      d_size_q    <= {TL_SIZE_BITS{1'b0}};
      d_source_q  <= {TL_SOURCE_BITS{1'b0}};
      d_denied_q  <= 1'b0;
      d_corrupt_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      d_opcode_q  <= d_opcode_d;
      d_size_q    <= d_size_d;
      d_source_q  <= d_source_d;
      d_denied_q  <= d_denied_d;
      d_corrupt_q <= d_corrupt_d;
    end
  end

  // SRAM write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < TL_DATA_BYTES; b++) begin
        if (a_mask[b]) mem_q[word_idx][8*b +: 8] <= a_data[8*b +: 8];
      end
    end
  end

  // SRAM read port feeding the response data register; zero for Puts and denied Gets.
  always_ff @(posedge clk) begin
    if (!rst_n) d_data_q <= {DW{1'b0}};
    else if (a_fire) d_data_q <= rd_en ? mem_q[word_idx] : {DW{1'b0}};
    else d_data_q <= d_data_q;
  end

  assign d_valid         = (state_q == ST_FULL);
  assign d_opcode        = d_opcode_q;
  assign d_size          = d_size_q;
  assign d_source        = d_source_q;
  assign d_denied        = d_denied_q;
  assign d_corrupt       = d_corrupt_q;
  assign d_data          = d_data_q;
  assign mem_write_valid = wr_en;
  assign mem_write_addr  = a_address;
  assign mem_write_data  = a_data;
  assign mem_write_mask  = a_mask;

endmodule

// File: tb/tb_tl_ul_mem_responder.sv
// Scoreboard bench for tl_ul_mem_responder: a driver pushes model responses at A-fire,
// a monitor pops and compares every cycle the DUT presents channel D.
module tb_tl_ul_mem_responder;
  localparam int AW = 32, DB = 4, SW = 3, SRCW = 8, DEPTH = 256;
  localparam logic [31:0] BASE = 32'h0;

  logic clk = 1'b0, rst_n = 1'b0;
  logic a_valid = 1'b0, a_ready, d_valid, d_ready = 1'b1;
  logic [2:0] a_opcode = 3'd0, a_param = 3'd0, d_opcode;
  logic [SW-1:0] a_size = '0, d_size;
  logic [SRCW-1:0] a_source = '0, d_source;
  logic [AW-1:0] a_address = '0, mem_write_addr;
  logic [DB-1:0] a_mask = '0, mem_write_mask;
  logic [31:0] a_data = '0, d_data, mem_write_data;
  logic d_denied, d_corrupt, mem_write_valid;

  tl_ul_mem_responder #(.TL_ADDR_BITS(AW), .TL_DATA_BYTES(DB), .TL_SIZE_BITS(SW),
    .TL_SOURCE_BITS(SRCW), .MEM_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode),
    .a_param(a_param), .a_size(a_size), .a_source(a_source), .a_address(a_address),
    .a_mask(a_mask), .a_data(a_data), .d_valid(d_valid), .d_ready(d_ready),
    .d_opcode(d_opcode), .d_size(d_size), .d_source(d_source), .d_denied(d_denied),
    .d_corrupt(d_corrupt), .d_data(d_data), .mem_write_valid(mem_write_valid),
    .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data),
    .mem_write_mask(mem_write_mask));

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op; logic [SW-1:0] size; logic [SRCW-1:0] src;
    logic denied; logic corrupt; logic [31:0] data; bit wr; int ready_cyc;
  } rsp_t;

  rsp_t q[$];
  logic [31:0] mdl [DEPTH];
  int vectors = 0, miscompares = 0, cyc = 0;
  bit mon_en = 1'b0, dr_rand = 1'b0;
  logic dr_level = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: TileLink-UL rules applied to a plain word array.
  function automatic rsp_t model_apply(input logic [2:0] op, input logic [2:0] prm,
      input logic [SW-1:0] size, input logic [SRCW-1:0] src, input logic [31:0] addr,
      input logic [3:0] mask, input logic [31:0] data);
    rsp_t r; longint off; int sz, lane, idx, full; bit put, get, deny;
    off  = longint'({32'd0, addr}) - longint'({32'd0, BASE});
    sz   = int'(size);
    lane = int'(addr % 32'd4);
    put  = (op == 3'd0) || (op == 3'd1);
    get  = (op == 3'd4);
    deny = 1'b0;
    idx  = 0;
    if (off < 0 || off >= longint'(DEPTH * DB)) deny = 1'b1;
    else idx = int'(off / DB);
    if (!(put || get)) deny = 1'b1;
    if (prm != 3'd0) deny = 1'b1;
    if (sz > 2) deny = 1'b1;
    else begin
      if (lane % (1 << sz) != 0) deny = 1'b1;
      full = ((1 << (1 << sz)) - 1) << lane;
      if (op == 3'd0 && int'(mask) != full) deny = 1'b1;
    end
    if (put && mask == 4'd0) deny = 1'b1;
    r.op = get ? 3'd1 : 3'd0;
    r.size = size; r.src = src; r.denied = deny; r.corrupt = get && deny;
    r.data = (get && !deny) ? mdl[idx] : 32'd0;
    r.wr = put && !deny;
    r.ready_cyc = 0;
    if (r.wr) for (int b = 0; b < 4; b++) if (mask[b]) mdl[idx][8*b +: 8] = data[8*b +: 8];
    return r;
  endfunction

  task automatic issue(input logic [2:0] op, input logic [2:0] prm, input logic [SW-1:0] size,
      input logic [SRCW-1:0] src, input logic [31:0] addr, input logic [3:0] mask,
      input logic [31:0] data, output int waited);
    rsp_t r; bit fired;
    fired = 1'b0; waited = 0;
    a_valid = 1'b1; a_opcode = op; a_param = prm; a_size = size; a_source = src;
    a_address = addr; a_mask = mask; a_data = data;
    while (!fired && waited < 100) begin
      @(negedge clk);
      if (a_ready) begin
        r = model_apply(op, prm, size, src, addr, mask, data);
        r.ready_cyc = cyc + 1;
        q.push_back(r);
        chk("mem_write_valid", mem_write_valid, r.wr);
        if (r.wr) begin
          chk("mem_write_addr", mem_write_addr, addr);
          chk("mem_write_data", mem_write_data, data);
          chk("mem_write_mask", mem_write_mask, mask);
        end
        fired = 1'b1;
      end else waited++;
      @(posedge clk); #1;
    end
    if (!fired) chk("issue_timeout", 1'b0, 1'b1);
    a_valid = 1'b0;
  endtask

  initial forever begin
    @(posedge clk); cyc++;
  end

  initial forever begin
    @(posedge clk); #1;
    d_ready = dr_rand ? 1'($urandom_range(0, 1)) : dr_level;
  end

  // Monitor: handshake rule, idle write strobe, and scoreboard comparison of channel D.
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      chk("a_ready_rule", a_ready, rst_n && (!d_valid || d_ready));
      if (!(a_valid && a_ready)) chk("mem_write_idle", mem_write_valid, 1'b0);
      if (d_valid) begin
        if (q.size() == 0) chk("unexpected_rsp", 1'b1, 1'b0);
        else begin
          chk("d_opcode", d_opcode, q[0].op);
          chk("d_size", d_size, q[0].size);
          chk("d_source", d_source, q[0].src);
          chk("d_denied", d_denied, q[0].denied);
          chk("d_corrupt", d_corrupt, q[0].corrupt);
          chk("d_data", d_data, q[0].data);
          if (d_ready) void'(q.pop_front());
        end
      end else if (q.size() > 0 && cyc >= q[0].ready_cyc) chk("rsp_latency", d_valid, 1'b1);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1);
  end

  initial begin
    int w;
    logic [31:0] ra; logic [SW-1:0] rs; logic [2:0] rop, rprm; logic [3:0] rm;
    logic [2:0] optab [8] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd4, 3'd4, 3'd4, 3'd2};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_d_valid", d_valid, 1'b0);
    chk("rst_a_ready", a_ready, 1'b0);
    chk("rst_mem_write_valid", mem_write_valid, 1'b0);
    chk("rst_d_fields", {d_opcode, d_size, d_source, d_denied, d_corrupt}, '0);
    chk("rst_d_data", d_data, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    chk("a_ready_after_reset", a_ready, 1'b1);
    mon_en = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < DEPTH; i++) issue(3'd0, 3'd0, 3'd2, 8'(i), 32'(i * 4), 4'hF, $urandom, w);

    // Directed: full write, read back, partial merge, denied cases.
    issue(3'd0, 3'd0, 3'd2, 8'h11, 32'h10, 4'hF, 32'hDEADBEEF, w);
    issue(3'd4, 3'd0, 3'd2, 8'h12, 32'h10, 4'hF, 32'h0, w);
    issue(3'd1, 3'd0, 3'd2, 8'h13, 32'h10, 4'h6, 32'h00AABB00, w);
    issue(3'd4, 3'd0, 3'd2, 8'h14, 32'h10, 4'hF, 32'h0, w);
    chk("partial_merge_model", mdl[4], 32'hDEAABBEF);
    issue(3'd4, 3'd0, 3'd2, 8'h20, 32'(DEPTH * DB), 4'hF, 32'h0, w);
    issue(3'd4, 3'd0, 3'd2, 8'h21, 32'h12, 4'hF, 32'h0, w);
    issue(3'd2, 3'd0, 3'd2, 8'h22, 32'h10, 4'hF, 32'h12345678, w);
    issue(3'd0, 3'd0, 3'd2, 8'h23, 32'h10, 4'h3, 32'h12345678, w);
    issue(3'd4, 3'd0, 3'd2, 8'h24, 32'h10, 4'hF, 32'h0, w);

    for (int i = 0; i < 8; i++) begin
      issue(3'd0, 3'd0, 3'd2, 8'(i), 32'h100 + 32'(i * 4), 4'hF, $urandom, w);
      chk("b2b_put_stall", w, 0);
    end
    for (int i = 0; i < 8; i++) begin
      issue(3'd4, 3'd0, 3'd2, 8'(8 + i), 32'h100 + 32'(i * 4), 4'hF, 32'h0, w);
      chk("b2b_get_stall", w, 0);
    end

    // Backpressure: response held five cycles, queued Get accepted on release.
    @(negedge clk); dr_level = 1'b0;
    @(posedge clk); #1;
    issue(3'd0, 3'd0, 3'd2, 8'h30, 32'h40, 4'hF, 32'hCAFEF00D, w);
    fork
      begin
        issue(3'd4, 3'd0, 3'd2, 8'h31, 32'h40, 4'hF, 32'h0, w);
        chk("bp_release_wait", w, 5);
      end
      begin
        repeat (5) begin
          @(negedge clk);
          chk("bp_a_ready", a_ready, 1'b0);
          chk("bp_d_valid", d_valid, 1'b1);
        end
        dr_level = 1'b1;
      end
    join

    // Reset with a pending response and a Put presented while rst_n is low.
    @(negedge clk); dr_level = 1'b0;
    @(posedge clk); #1;
    issue(3'd0, 3'd0, 3'd2, 8'h40, 32'h50, 4'hF, 32'h5A5AA5A5, w);
    mon_en = 1'b0; rst_n = 1'b0;
    a_valid = 1'b1; a_opcode = 3'd0; a_param = 3'd0; a_size = 3'd2;
    a_address = 32'h54; a_mask = 4'hF; a_data = 32'h0BADC0DE;
    @(negedge clk);
    chk("mid_rst_a_ready", a_ready, 1'b0);
    chk("mid_rst_mem_write", mem_write_valid, 1'b0);
    @(posedge clk); #2;
    chk("post_rst_d_valid", d_valid, 1'b0);
    chk("post_rst_a_ready", a_ready, 1'b0);
    rst_n = 1'b1; a_valid = 1'b0; q.delete(); dr_level = 1'b1;
    @(negedge clk);
    chk("release_a_ready", a_ready, 1'b1);
    mon_en = 1'b1;
    @(posedge clk); #1;
    issue(3'd4, 3'd0, 3'd2, 8'h41, 32'h50, 4'hF, 32'h0, w);
    issue(3'd4, 3'd0, 3'd2, 8'h42, 32'h54, 4'hF, 32'h0, w);

    // Randomized traffic with random backpressure and idle gaps.
    dr_rand = 1'b1;
    for (int n = 0; n < 400; n++) begin
      rop  = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(5, 7)) : optab[$urandom_range(0, 7)];
      rprm = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      rs   = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      if ($urandom_range(0, 9) == 0) ra = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1024, 4095)) : $urandom;
      else ra = 32'($urandom_range(0, DEPTH * DB - 1));
      if (rs <= 3'd2 && $urandom_range(0, 3) != 0) ra = (ra >> rs) << rs;
      if (rs <= 3'd2 && $urandom_range(0, 2) != 0) rm = 4'(((1 << (1 << rs)) - 1) << (ra % 32'd4));
      else rm = 4'($urandom_range(0, 15));
      issue(rop, rprm, rs, 8'($urandom_range(0, 255)), ra, rm, $urandom, w);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    dr_rand = 1'b0; dr_level = 1'b1;
    for (int i = 0; i < 50 && q.size() > 0; i++) @(posedge clk);
    @(negedge clk); @(negedge clk);
    chk("drain_queue_empty", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
